mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 28 ++
 rtl/rd_tag_pipe.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the two-core memory port arbiter:
//   ADDR_W / DATA_W : word address width [15:1] and data width
//   owner_e         : which core owns an access (CORE0 = 0, CORE1 = 1)
//   rd_tag_t        : one stage of the read-return tracking pipe
//   sat_inc8        : 8-bit saturating increment used by the stall counters
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : mem_pkg

// File: rtl/rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// RD_LAT-deep shift register of {valid, owner} tags. A tag pushed with a read
// grant appears on the output exactly RD_LAT cycles later, which is when the
// memory presents the matching read data.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   i_push    : a read was granted this cycle
//   i_owner   : core that owns the granted read (0 / 1)
//   o_valid   : read data on m_rdata belongs to a tracked read this cycle
//   o_owner   : owner of that read
// -----------------------------------------------------------------------------
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner
);

  rd_tag_t r_pipe [RD_LAT];

  // NOTE: only the valid bits need clearing so in-flight reads are dropped;
  // the owner bits are cleared with them simply to keep the pipe deterministic.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value and the shift is race-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: i_push, owner: owner_e'(i_owner)};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_valid = r_pipe[RD_LAT-1].valid;
  assign o_owner = r_pipe[RD_LAT-1].owner;

endmodule : rd_tag_pipe

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between two cores. One access is granted
// per cycle; grant is combinational from the requests and a priority pointer
// (round-robin, or core 0 always wins when FIXED_PRI=1). Read returns are
// routed back to the owning core RD_LAT cycles after the grant.
//   clk, rst                 : rising-edge clock, async active-high reset
//   cN_req/wen/addr/wdata    : core N request (N = 0, 1)
//   cN_gnt                   : core N request accepted this cycle
//   cN_rvalid / cN_rdata     : read return for core N (rdata mirrors m_rdata)
//   cN_stall_cnt             : saturating count of cycles core N waited
//   m_ren/m_wen/m_addr/m_wdata : memory command for the granted core
//   m_rdata                  : memory read data, RD_LAT cycles after m_ren
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_wen,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [7:0]        c0_stall_cnt,
  input  logic              c1_req,
  input  logic              c1_wen,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [7:0]        c1_stall_cnt,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  owner_e     r_ptr;
  logic [7:0] r_stall0;
  logic [7:0] r_stall1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_tag_valid;
  logic       w_tag_owner;

  // Grant: a lone requester always wins; on contention the pointer (or core 0
  // under fixed priority) decides. Forced low while in reset.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (c0_req && c1_req) begin
        if (FIXED_PRI != 0 || r_ptr == CORE0) w_gnt0 = 1'b1;
        else                                  w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = c0_req;
        w_gnt1 = c1_req;
      end
    end
  end

  // Memory command mux: idle bus is all zeros.
  always_comb begin
    m_ren   = 1'b0;
    m_wen   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_gnt0) begin
      m_ren   = ~c0_wen;
      m_wen   = c0_wen;
      m_addr  = c0_addr;
      m_wdata = c0_wdata;
    end else if (w_gnt1) begin
      m_ren   = ~c1_wen;
      m_wen   = c1_wen;
      m_addr  = c1_addr;
      m_wdata = c1_wdata;
    end
  end

  // Pointer always moves to the core that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= CORE0;
    end else if (w_gnt0) begin
      r_ptr <= CORE1;
    end else if (w_gnt1) begin
      r_ptr <= CORE0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      if (c0_req && !w_gnt0) r_stall0 <= sat_inc8(r_stall0);
      if (c1_req && !w_gnt1) r_stall1 <= sat_inc8(r_stall1);
    end
  end

  // m_ren is only high for a granted read, and w_gnt1 names its owner then.
  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_push  (m_ren),
    .i_owner (w_gnt1),
    .o_valid (w_tag_valid),
    .o_owner (w_tag_owner)
  );

  assign c0_gnt       = w_gnt0;
  assign c1_gnt       = w_gnt1;
  assign c0_rvalid    = !rst && w_tag_valid && (w_tag_owner == CORE0);
  assign c1_rvalid    = !rst && w_tag_valid && (w_tag_owner == CORE1);
  assign c0_rdata     = m_rdata;
  assign c1_rdata     = m_rdata;
  assign c0_stall_cnt = r_stall0;
  assign c1_stall_cnt = r_stall1;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiter instances share one stimulus stream:
//   k=0 : RD_LAT=1, round-robin
//   k=1 : RD_LAT=3, round-robin
//   k=2 : RD_LAT=2, fixed priority
// Each instance has its own memory behind it. A per-instance reference model
// (pointer as an int, stall counts as ints, a due-cycle table of expected read
// returns and a model copy of memory contents) predicts every output.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NI     = 3;
  localparam int LAT[NI] = '{1, 3, 2};
  localparam int FP[NI]  = '{0, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c0_req = 1'b0, c0_wen = 1'b0, c1_req = 1'b0, c1_wen = 1'b0;
  logic [14:0] c0_addr = '0, c1_addr = '0;
  logic [15:0] c0_wdata = '0, c1_wdata = '0;

  logic        g0 [NI], g1 [NI], rv0 [NI], rv1 [NI], mren [NI], mwen [NI];
  logic [14:0] maddr [NI];
  logic [15:0] mwdata [NI], rd0 [NI], rd1 [NI];
  logic [7:0]  st0 [NI], st1 [NI];

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int k, input int a);
    return 16'((a * 263) ^ (k << 12) ^ 16'h3C00);
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 2;
    localparam int F = (k == 2) ? 1 : 0;

    logic [15:0] env_mem [512];
    logic [15:0] env_rd  [4];

    mem_port_arbiter #(
      .RD_LAT    (L),
      .FIXED_PRI (F)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .c0_req       (c0_req),
      .c0_wen       (c0_wen),
      .c0_addr      (c0_addr),
      .c0_wdata     (c0_wdata),
      .c0_gnt       (g0[k]),
      .c0_rvalid    (rv0[k]),
      .c0_rdata     (rd0[k]),
      .c0_stall_cnt (st0[k]),
      .c1_req       (c1_req),
      .c1_wen       (c1_wen),
      .c1_addr      (c1_addr),
      .c1_wdata     (c1_wdata),
      .c1_gnt       (g1[k]),
      .c1_rvalid    (rv1[k]),
      .c1_rdata     (rd1[k]),
      .c1_stall_cnt (st1[k]),
      .m_ren        (mren[k]),
      .m_wen        (mwen[k]),
      .m_addr       (maddr[k]),
      .m_wdata      (mwdata[k]),
      .m_rdata      (env_rd[L-1])
    );

    // Memory behind the arbiter: reads sampled at the command cycle and
    // presented L cycles later.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 512; i++) env_mem[i] <= init_word(k, i);
      end else if (mwen[k]) begin
        env_mem[maddr[k][8:0]] <= mwdata[k];
      end
      env_rd[0] <= env_mem[maddr[k][8:0]];
      for (int i = 1; i < 4; i++) env_rd[i] <= env_rd[i-1];
    end
  end

  // ---------------------------------------------------------------- checking
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  int          m_ptr [NI];
  int          m_st0 [NI], m_st1 [NI];
  bit          due_v [NI][8];
  bit          due_o [NI][8];
  logic [15:0] due_d [NI][8];
  logic [15:0] mmem  [NI][512];
  int          cyc = 0;

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_ptr[k] = 0;
      m_st0[k] = 0;
      m_st1[k] = 0;
      for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
      for (int a = 0; a < 512; a++) mmem[k][a] = init_word(k, a);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model mid-low-phase, then advance the model past the next
  // rising edge.
  task automatic step(input bit r,
                      input bit q0, input bit w0, input logic [14:0] a0, input logic [15:0] d0,
                      input bit q1, input bit w1, input logic [14:0] a1, input logic [15:0] d1);
    bit          e0, e1, er, ew, ev0, ev1;
    logic [14:0] ea;
    logic [15:0] ed;
    int          s;
    @(negedge clk);
    rst = r;
    c0_req = q0; c0_wen = w0; c0_addr = a0; c0_wdata = d0;
    c1_req = q1; c1_wen = w1; c1_addr = a1; c1_wdata = d1;
    #1;
    if (r) model_reset();
    s = cyc % 8;
    for (int k = 0; k < NI; k++) begin
      e0 = 1'b0; e1 = 1'b0;
      if (!r) begin
        if (q0 && q1) begin
          if (FP[k] != 0 || m_ptr[k] == 0) e0 = 1'b1;
          else                             e1 = 1'b1;
        end else begin
          e0 = q0;
          e1 = q1;
        end
      end
      er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
      if (e0)      begin er = !w0; ew = w0; ea = a0; ed = d0; end
      else if (e1) begin er = !w1; ew = w1; ea = a1; ed = d1; end
      ev0 = due_v[k][s] && !due_o[k][s];
      ev1 = due_v[k][s] &&  due_o[k][s];

      check($sformatf("k%0d c0_gnt", k),    32'(g0[k]),     32'(e0));
      check($sformatf("k%0d c1_gnt", k),    32'(g1[k]),     32'(e1));
      check($sformatf("k%0d m_ren", k),     32'(mren[k]),   32'(er));
      check($sformatf("k%0d m_wen", k),     32'(mwen[k]),   32'(ew));
      check($sformatf("k%0d m_addr", k),    32'(maddr[k]),  32'(ea));
      check($sformatf("k%0d m_wdata", k),   32'(mwdata[k]), 32'(ed));
      check($sformatf("k%0d c0_rvalid", k), 32'(rv0[k]),    32'(ev0));
      check($sformatf("k%0d c1_rvalid", k), 32'(rv1[k]),    32'(ev1));
      if (ev0) check($sformatf("k%0d c0_rdata", k), 32'(rd0[k]), 32'(due_d[k][s]));
      if (ev1) check($sformatf("k%0d c1_rdata", k), 32'(rd1[k]), 32'(due_d[k][s]));
      check($sformatf("k%0d c0_stall", k),  32'(st0[k]),    32'(m_st0[k]));
      check($sformatf("k%0d c1_stall", k),  32'(st1[k]),    32'(m_st1[k]));

      // advance the model to the next cycle
      due_v[k][s] = 1'b0;
      if (!r) begin
        if (e0) m_ptr[k] = 1;
        if (e1) m_ptr[k] = 0;
        if (q0 && !e0 && m_st0[k] < 255) m_st0[k]++;
        if (q1 && !e1 && m_st1[k] < 255) m_st1[k]++;
        if (er) begin
          due_v[k][(cyc + LAT[k]) % 8] = 1'b1;
          due_o[k][(cyc + LAT[k]) % 8] = e1;
          due_d[k][(cyc + LAT[k]) % 8] = mmem[k][ea[8:0]];
        end
        if (ew) mmem[k][ea[8:0]] = ed;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  function automatic logic [14:0] rand_addr();
    return 15'($urandom_range(0, 15) | ($urandom_range(0, 1) << 8));
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit          r, q0, w0, q1, w1;
    logic [14:0] a0, a1;
    logic [15:0] d0, d1;

    model_reset();
    // reset state
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    step(1, 1, 0, 15'h1, 16'h1, 1, 1, 15'h2, 16'h2);
    idle(4);

    // lone core-0 read of 0x0010
    step(0, 1, 0, 15'h0010, 16'h0, 0, 0, '0, '0);
    idle(5);

    // both cores contend for six cycles straight out of reset
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    repeat (6) step(0, 1, 0, 15'h0003, 16'h0, 1, 0, 15'h0004, 16'h0);
    idle(5);

    // core 1 writes 0xBEEF to 0x0100, then core 0 reads it back
    step(0, 0, 0, '0, '0, 1, 1, 15'h0100, 16'hBEEF);
    step(0, 1, 0, 15'h0100, 16'h0, 0, 0, '0, '0);
    idle(5);

    // back-to-back reads c0, c1, c0
    step(0, 1, 0, 15'h0005, 16'h0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 1, 0, 15'h0006, 16'h0);
    step(0, 1, 0, 15'h0100, 16'h0, 0, 0, '0, '0);
    idle(6);

    // reset one cycle after a read grant: the read must vanish
    step(0, 0, 0, '0, '0, 1, 0, 15'h0007, 16'h0);
    step(0, 1, 0, 15'h0008, 16'h0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    idle(5);
    step(0, 1, 0, 15'h0009, 16'h0, 1, 0, 15'h000A, 16'h0);
    idle(5);

    // long contention: fixed-priority core 1 stall count must pin at 255
    repeat (300) step(0, 1, 0, rand_addr(), 16'(17), 1, 1, rand_addr(), 16'($urandom));
    check("k2 c1_stall saturated", 32'(st1[2]), 32'd255);
    idle(5);

    // randomized traffic with occasional resets
    repeat (700) begin
      r  = ($urandom_range(0, 99) == 0);
      q0 = ($urandom_range(0, 9) < 7);
      w0 = ($urandom_range(0, 2) == 0);
      a0 = rand_addr();
      d0 = 16'($urandom);
      q1 = ($urandom_range(0, 9) < 7);
      w1 = ($urandom_range(0, 2) == 0);
      a1 = rand_addr();
      d1 = 16'($urandom);
      step(r, q0, w0, a0, d0, q1, w1, a1, d1);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
